uart_rx: RTL and testbench

//   Serial UART receiver, companion to uart_tx: 8 data bits LSB first, 1 start, 1 stop, no parity.

---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling, and a single-byte output register
// with a valid/read handshake, one-cycle framing-error pulse and sticky overrun flag.
module uart_rx #(
   parameter int unsigned BAUD  = 115200,
   parameter int unsigned CLOCK = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxPin,
   input  logic       rdEn,
   output logic [7:0] dout,
   output logic       dataValid,
   output logic       frameErr,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = CLOCK / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned WIDTH        = $clog2(CLKS_PER_BIT);

   localparam logic [WIDTH-1:0] HALF_LAST = WIDTH'(HALF_BIT - 1);
   localparam logic [WIDTH-1:0] BIT_LAST  = WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [WIDTH-1:0] TIMER_ONE = WIDTH'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } state_e;

   state_e            state_q, state_d;
   logic              sync1_q, rxs_q;
   logic [WIDTH-1:0]  timer_q, timer_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;
   logic              busy_q, busy_d;
   logic              good_stop;
   logic              rd_ack;

   // State and datapath registers; reset wins over everything, mid-frame included.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         sync1_q   <= 1'b1;
         rxs_q     <= 1'b1;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= rxPin;
         rxs_q     <= sync1_q;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         busy_q    <= busy_d;
      end
   end

   // Frame sequencing plus output handshake; timer compares use the registered count.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      ferr_d    = 1'b0;
      good_stop = 1'b0;
      rd_ack    = rdEn & valid_q;

      case (state_q)
         ST_IDLE: begin
            timer_d   = '0;
            bit_idx_d = '0;
            if (!rxs_q) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (timer_q == HALF_LAST) begin
               timer_d = '0;
               state_d = rxs_q ? ST_IDLE : ST_DATA;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         ST_DATA: begin
            if (timer_q == BIT_LAST) begin
               timer_d           = '0;
               shift_d[bit_idx_q] = rxs_q;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         ST_STOP: begin
            if (timer_q == BIT_LAST) begin
               timer_d = '0;
               if (rxs_q) begin
                  good_stop = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_WAIT_HIGH;
               end
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         // A held-low (break) line must return high before another start is accepted.
         ST_WAIT_HIGH: begin
            timer_d = '0;
            if (rxs_q) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            bit_idx_d = '0;
         end
      endcase

      if (rd_ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      // A read on the same edge as a new byte consumes the old one, so no overrun.
      if (good_stop) begin
         dout_d  = shift_q;
         valid_d = 1'b1;
         if (valid_q && !rdEn) begin
            ovr_d = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign dout      = dout_q;
   assign dataValid = valid_q;
   assign frameErr  = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx against a frame-level model of the byte register,
// valid/read handshake and overrun rules.
module tb_uart_rx;

   localparam int CLOCK = 1600000;
   localparam int BAUD  = 100000;
   localparam int CPB   = CLOCK / BAUD;
   localparam int HALF  = CPB / 2;
   localparam int LAT   = 2 + HALF + 9 * CPB;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       rxPin = 1'b1;
   logic       rdEn  = 1'b0;
   logic [7:0] dout;
   logic       dataValid;
   logic       frameErr;
   logic       overrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_dout  = 8'h00;
   logic       exp_valid = 1'b0;
   logic       exp_ovr   = 1'b0;

   always #5 clk = ~clk;

   uart_rx #(.BAUD(BAUD), .CLOCK(CLOCK)) dut (
      .clk       (clk),
      .rst       (rst),
      .rxPin     (rxPin),
      .rdEn      (rdEn),
      .dout      (dout),
      .dataValid (dataValid),
      .frameErr  (frameErr),
      .overrun   (overrun),
      .busy      (busy)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_dout"},  32'(dout),      32'(exp_dout));
      chk({tag, "_valid"}, 32'(dataValid), 32'(exp_valid));
      chk({tag, "_ovr"},   32'(overrun),   32'(exp_ovr));
   endtask

   // Model: a good frame lands in the register; an unread byte being replaced is an overrun
   // unless the consumer reads on that very edge.
   task automatic model_good(input logic [7:0] b, input logic rd_same);
      if (exp_valid && !rd_same) exp_ovr = 1'b1;
      else if (exp_valid && rd_same) exp_ovr = 1'b0;
      exp_dout  = b;
      exp_valid = 1'b1;
   endtask

   task automatic model_read();
      if (exp_valid) begin
         exp_valid = 1'b0;
         exp_ovr   = 1'b0;
      end
   endtask

   task automatic pulse_rd();
      rdEn = 1'b1;
      tick(1);
      rdEn = 1'b0;
   endtask

   // Drives start, 8 data bits LSB first and the stop bit; records dataValid rise and frameErr pulses.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int rd_at,
                             output int rise_at, output int ferr_n);
      logic prev_v;
      rise_at = -1;
      ferr_n  = 0;
      for (int c = 0; c < 10 * CPB; c++) begin
         int k;
         k = c / CPB;
         if (k == 0) rxPin = 1'b0;
         else if (k <= 8) rxPin = b[k-1];
         else rxPin = stop_v;
         rdEn   = (c == rd_at);
         prev_v = dataValid;
         tick(1);
         if (!prev_v && dataValid && rise_at < 0) rise_at = c + 1;
         if (frameErr) ferr_n++;
      end
      rdEn = 1'b0;
   endtask

   initial begin
      int rise, fn, bh, fe;
      logic [7:0] rb;
      logic good;

      // Reset state
      rst = 1'b0;
      tick(3);
      chk("rst_dout",  32'(dout),      32'h0);
      chk("rst_valid", 32'(dataValid), 32'h0);
      chk("rst_ferr",  32'(frameErr),  32'h0);
      chk("rst_ovr",   32'(overrun),   32'h0);
      chk("rst_busy",  32'(busy),      32'h0);
      rst = 1'b1;
      tick(4);

      // 1) 0xA5 with good stop and latency window
      send_frame(8'hA5, 1'b1, -1, rise, fn);
      rxPin = 1'b1;
      tick(CPB);
      model_good(8'hA5, 1'b0);
      chk_model("t1");
      chk("t1_latency_in_window", 32'(rise >= LAT - 1 && rise <= LAT + 1), 32'h1);
      chk("t1_ferr", 32'(fn), 32'h0);
      pulse_rd();
      model_read();
      chk_model("t1_read");

      // 2) false start: line low 4 clocks only
      bh = 0;
      fe = 0;
      for (int c = 0; c < 24; c++) begin
         rxPin = (c >= 4);
         tick(1);
         if (busy) bh++;
         if (frameErr) fe++;
      end
      chk("t2_busy_bounded", 32'(bh >= 1 && bh <= HALF), 32'h1);
      chk("t2_busy_end", 32'(busy), 32'h0);
      chk("t2_ferr", 32'(fe), 32'h0);
      chk_model("t2");

      // 3) 0x3C with low stop, line held low 40 clocks afterwards
      send_frame(8'h3C, 1'b0, -1, rise, fn);
      bh = 0;
      for (int c = 0; c < 40; c++) begin
         tick(1);
         if (frameErr) fn++;
         if (busy) bh++;
      end
      chk("t3_ferr_once", 32'(fn), 32'h1);
      chk("t3_held_busy", 32'(bh), 32'd40);
      chk_model("t3");
      rxPin = 1'b1;
      tick(4);
      chk("t3_idle_after_high", 32'(busy), 32'h0);
      chk_model("t3_after");

      // 4) two bytes unread -> overrun, then read clears
      send_frame(8'h11, 1'b1, -1, rise, fn);
      rxPin = 1'b1;
      tick(8);
      model_good(8'h11, 1'b0);
      send_frame(8'h22, 1'b1, -1, rise, fn);
      rxPin = 1'b1;
      tick(8);
      model_good(8'h22, 1'b0);
      chk_model("t4");
      pulse_rd();
      model_read();
      chk_model("t4_read");
      pulse_rd();
      model_read();
      chk_model("t4_read_idle");

      // 5) read on the completing edge: the fall is driven just after an edge, so the
      //    byte lands on edge LAT+1 and rdEn must be up during cycle LAT
      send_frame(8'h11, 1'b1, -1, rise, fn);
      rxPin = 1'b1;
      tick(8);
      model_good(8'h11, 1'b0);
      send_frame(8'h22, 1'b1, LAT, rise, fn);
      rxPin = 1'b1;
      tick(8);
      model_good(8'h22, 1'b1);
      chk_model("t5");

      // 6) reset in DATA bit 3 of 0xFF, then 0x5A
      for (int c = 0; c < 4 * CPB + 4; c++) begin
         rxPin = (c >= CPB);
         tick(1);
      end
      chk("t6_busy_pre", 32'(busy), 32'h1);
      rst = 1'b0;
      tick(1);
      exp_dout  = 8'h00;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      chk_model("t6_rst");
      chk("t6_rst_ferr", 32'(frameErr), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      rst   = 1'b1;
      rxPin = 1'b1;
      tick(2 * CPB);
      send_frame(8'h5A, 1'b1, -1, rise, fn);
      rxPin = 1'b1;
      tick(8);
      model_good(8'h5A, 1'b0);
      chk_model("t6_5a");

      // Randomized frames, stop-bit errors and reads against the model
      for (int i = 0; i < 12; i++) begin
         rb   = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send_frame(rb, good, -1, rise, fn);
         rxPin = 1'b1;
         tick(8);
         if (good) model_good(rb, 1'b0);
         chk_model("rnd");
         chk("rnd_ferr", 32'(fn), good ? 32'h0 : 32'h1);
         if ($urandom_range(0, 1) != 0) begin
            pulse_rd();
            model_read();
            chk_model("rnd_read");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
